// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: instruction-memory port between the fetch stage and the memory.
//   master (fetch side) : drives req_valid_o/req_addr_o, receives ready and the response
//   slave  (memory side): receives the request, drives ready and the response
//   req_valid_o  request valid         req_addr_o  request address
//   req_ready_i  memory accepts        resp_valid_i response valid
//   resp_data_i  fetched instruction   resp_err_i  access fault for this response
interface ifu_fetch_if #(
  parameter int XLEN     = 64,
  parameter int INST_LEN = 32
);
  logic                req_valid_o;
  logic [XLEN-1:0]     req_addr_o;
  logic                req_ready_i;
  logic                resp_valid_i;
  logic [INST_LEN-1:0] resp_data_i;
  logic                resp_err_i;

  modport master (
    output req_valid_o, req_addr_o,
    input  req_ready_i, resp_valid_i, resp_data_i, resp_err_i
  );

  modport slave (
    input  req_valid_o, req_addr_o,
    output req_ready_i, resp_valid_i, resp_data_i, resp_err_i
  );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch stage feeding the IF/ID register. Owns the PC, keeps at
// most one request outstanding on the memory port and holds the returned word until
// IF/ID takes it. A bubble is presented as {PC_RESET_ADDR-4, INST_NOP, no trap}.
//   clk, rst       clock, synchronous active-high reset
//   stall_i        IF/ID not accepting; the held word stays presented
//   redirect_i     PC redirect (branch/trap); highest priority
//   redirect_pc_i  redirect target
//   mem            instruction-memory port (master side)
//   inst_addr_o    instruction address to IF/ID
//   inst_data_o    instruction word to IF/ID
//   trap_bus_o     bit0 = misaligned fetch address, bit1 = access fault
//
// state | meaning
// IDLE  | first cycle out of reset, nothing issued
// REQ   | presenting a request at pc (or trapping a misaligned pc)
// WAIT  | request accepted, waiting for its response (drop = discard it)
// FULL  | word held and presented to IF/ID
module ifu_fetch #(
  parameter int                  XLEN          = 64,
  parameter int                  INST_LEN      = 32,
  parameter int                  TRAP_LEN      = 2,
  parameter logic [XLEN-1:0]     PC_RESET_ADDR = 64'h8000_0000,
  parameter logic [INST_LEN-1:0] INST_NOP      = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                redirect_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  ifu_fetch_if.master         mem,
  output logic [XLEN-1:0]     inst_addr_o,
  output logic [INST_LEN-1:0] inst_data_o,
  output logic [TRAP_LEN-1:0] trap_bus_o
);

  localparam logic [XLEN-1:0]     BUBBLE_ADDR     = PC_RESET_ADDR - XLEN'(4);
  localparam logic [TRAP_LEN-1:0] TRAP_MISALIGNED = TRAP_LEN'(1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FULL} state_t;

  state_t              r_state;
  logic [XLEN-1:0]     r_pc;
  logic                r_drop;
  // Held word doubles as the IF/ID output register; it carries the bubble outside FULL.
  logic [XLEN-1:0]     r_out_addr;
  logic [INST_LEN-1:0] r_out_data;
  logic [TRAP_LEN-1:0] r_out_trap;

  logic w_misaligned;
  logic w_req_valid;

  assign w_misaligned = |r_pc[1:0];
  // A redirect in REQ retargets the pc first, so no handshake may happen that cycle.
  assign w_req_valid  = (r_state == S_REQ) && !redirect_i && !w_misaligned;

  assign mem.req_valid_o = w_req_valid;
  assign mem.req_addr_o  = r_pc;
  assign inst_addr_o     = r_out_addr;
  assign inst_data_o     = r_out_data;
  assign trap_bus_o      = r_out_trap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= PC_RESET_ADDR;
      r_drop     <= 1'b0;
      r_out_addr <= BUBBLE_ADDR;
      r_out_data <= INST_NOP;
      r_out_trap <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: r_state <= S_REQ;

        S_REQ: begin
          if (redirect_i) begin
            r_pc <= redirect_pc_i;
          end else if (w_misaligned) begin
            r_out_addr <= r_pc;
            r_out_data <= INST_NOP;
            r_out_trap <= TRAP_MISALIGNED;
            r_state    <= S_FULL;
          end else if (mem.req_ready_i) begin
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (mem.resp_valid_i && redirect_i) begin
            // The arriving response is the only one in flight, so any pending drop is satisfied.
            r_pc    <= redirect_pc_i;
            r_drop  <= 1'b0;
            r_state <= S_REQ;
          end else if (redirect_i) begin
            r_pc   <= redirect_pc_i;
            r_drop <= 1'b1;
          end else if (mem.resp_valid_i && r_drop) begin
            r_drop  <= 1'b0;
            r_state <= S_REQ;
          end else if (mem.resp_valid_i) begin
            r_out_addr <= r_pc;
            r_out_data <= mem.resp_data_i;
            r_out_trap <= TRAP_LEN'({mem.resp_err_i, 1'b0});
            r_state    <= S_FULL;
          end
        end

        S_FULL: begin
          if (redirect_i) begin
            r_pc       <= redirect_pc_i;
            r_out_addr <= BUBBLE_ADDR;
            r_out_data <= INST_NOP;
            r_out_trap <= '0;
            r_state    <= S_REQ;
          end else if (!stall_i) begin
            r_pc       <= r_pc + XLEN'(4);
            r_out_addr <= BUBBLE_ADDR;
            r_out_data <= INST_NOP;
            r_out_trap <= '0;
            r_state    <= S_REQ;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
